px_stream_bridge: RTL and testbench

PX_STREAM_BRIDGE -- requirements
Module: px_stream_bridge

---
 rtl/px_stream_bridge.sv | 87 ++++++++
 tb/tb_px_stream_bridge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/px_stream_bridge.sv
// px_stream_bridge: show-ahead FIFO from SD words to LCD words with a byte-order transform
// applied at push, block counting on pops, and frame_start flush.
module px_stream_bridge #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int BLK_WORDS = 128,
    parameter int BLK_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic [1:0]               swap_mode,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_trigger,
    output logic                     in_busy,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     blk_done,
    output logic [BLK_CNT_W-1:0]     blk_count,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = DATA_W / 16;
    localparam int NB    = DATA_W / 8;
    localparam int WCW   = BLK_WORDS > 1 ? $clog2(BLK_WORDS) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [WCW-1:0]    wcnt;
    logic [DATA_W-1:0] sw1, sw2, sw3, xf;
    logic              full, push, pop, last;

    // With an odd lane count the top lane has no partner and stays in place.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int J = ((i ^ 1) < LANES) ? (i ^ 1) : i;
        assign sw1[16*i +: 16] = {in_data[16*i +: 8], in_data[16*i+8 +: 8]};
        assign sw3[16*i +: 16] = in_data[16*J +: 16];
    end

    for (genvar i = 0; i < NB; i++) begin : g_byte
        assign sw2[8*i +: 8] = in_data[8*(NB-1-i) +: 8];
    end

    assign xf        = swap_mode == 2'd0 ? in_data :
                       swap_mode == 2'd1 ? sw1 :
                       swap_mode == 2'd2 ? sw2 : sw3;
    assign full      = level == FULL;
    assign in_busy   = full;
    assign out_valid = level != '0;
    assign out_data  = mem[rd_ptr];
    assign push      = in_trigger && !full;
    assign pop       = out_valid && out_ready;
    assign last      = wcnt == WCW'(BLK_WORDS - 1);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk)
        if (push && rst_n && !frame_start)
            mem[wr_ptr] <= xf;

    always_ff @(posedge clk) begin
        if (!rst_n || frame_start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            wcnt      <= '0;
            blk_count <= '0;
            blk_done  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level    <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            blk_done <= pop && last;
            if (in_trigger && full)
                overflow <= 1'b1;
            if (pop)
                wcnt <= last ? '0 : wcnt + 1'b1;
            if (pop && last)
                blk_count <= blk_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_px_stream_bridge.sv
// tb_px_stream_bridge: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with frame_start and reset.
module tb_px_stream_bridge;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 16;
    localparam int BLK_WORDS = 128;
    localparam int BLK_CNT_W = 16;
    localparam int NB        = DATA_W / 8;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic                 clk = 0;
    logic                 rst_n = 0;
    logic                 frame_start = 0;
    logic [1:0]           swap_mode = 0;
    logic [DATA_W-1:0]    in_data = 0;
    logic                 in_trigger = 0;
    logic                 in_busy;
    logic [DATA_W-1:0]    out_data;
    logic                 out_valid;
    logic                 out_ready = 0;
    logic                 blk_done;
    logic [BLK_CNT_W-1:0] blk_count;
    logic [LW-1:0]        level;
    logic                 overflow;

    px_stream_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BLK_WORDS(BLK_WORDS), .BLK_CNT_W(BLK_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .swap_mode(swap_mode),
        .in_data(in_data), .in_trigger(in_trigger), .in_busy(in_busy), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .blk_done(blk_done),
        .blk_count(blk_count), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 0;

    logic [DATA_W-1:0]    q [$];
    logic                 m_ovf = 0;
    logic                 m_bd = 0;
    logic [BLK_CNT_W-1:0] m_bc = 0;
    int                   m_wc = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Byte k of the result is byte src of the input.
    function automatic logic [DATA_W-1:0] ref_xf(input logic [DATA_W-1:0] d, input logic [1:0] m);
        logic [DATA_W-1:0] r;
        int src, ln;
        r = '0;
        for (int k = 0; k < NB; k++) begin
            ln = ((k / 2) ^ 1) < NB / 2 ? ((k / 2) ^ 1) : k / 2;
            case (m)
                2'd0: src = k;
                2'd1: src = k ^ 1;
                2'd2: src = NB - 1 - k;
                default: src = ln * 2 + k % 2;
            endcase
            r[8*k +: 8] = d[8*src +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n || frame_start) begin
            q.delete();
            m_ovf = 0;
            m_bc = 0;
            m_wc = 0;
            m_bd = 0;
        end else begin
            automatic bit was_full = q.size() == DEPTH;
            m_bd = 0;
            if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
                m_wc++;
                if (m_wc == BLK_WORDS) begin
                    m_wc = 0;
                    m_bc++;
                    m_bd = 1;
                end
            end
            if (in_trigger) begin
                if (was_full) m_ovf = 1;
                else q.push_back(ref_xf(in_data, swap_mode));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("level", 64'(level), 64'(q.size()));
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            check("in_busy", 64'(in_busy), 64'(q.size() == DEPTH));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("blk_count", 64'(blk_count), 64'(m_bc));
            check("blk_done", 64'(blk_done), 64'(m_bd));
            if (q.size() != 0) check("out_data", 64'(out_data), 64'(q[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        check("pin_xf0", 64'(ref_xf(32'h11223344, 2'd0)), 64'h11223344);
        check("pin_xf1", 64'(ref_xf(32'h11223344, 2'd1)), 64'h22114433);
        check("pin_xf2", 64'(ref_xf(32'h01020304, 2'd2)), 64'h04030201);
        check("pin_xf3", 64'(ref_xf(32'h11223344, 2'd3)), 64'h33441122);

        tick();
        tick();
        chk_en = 1;
        rst_n = 1;
        check("rst_level", 64'(level), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);

        // single word through swap mode 1
        swap_mode = 2'd1; in_data = 32'h11223344; in_trigger = 1; out_ready = 1;
        tick();
        in_trigger = 0;
        check("pass_valid", 64'(out_valid), 64'd1);
        check("pass_data", 64'(out_data), 64'h22114433);
        tick();
        check("pass_level", 64'(level), 64'd0);

        // fill to full and overflow
        out_ready = 0; swap_mode = 2'd0;
        for (int i = 0; i < 17; i++) begin
            in_data = 32'h100 + i; in_trigger = 1;
            tick();
        end
        in_trigger = 0;
        check("fill_level", 64'(level), 64'd16);
        check("fill_busy", 64'(in_busy), 64'd1);
        check("fill_ovf", 64'(overflow), 64'd1);
        check("fill_head", 64'(out_data), 64'h100);
        out_ready = 1;
        repeat (16) tick();
        check("drain_level", 64'(level), 64'd0);

        // two full blocks with byte reversal
        frame_start = 1;
        tick();
        frame_start = 0; swap_mode = 2'd2;
        for (int i = 0; i < 256; i++) begin
            in_data = (i == 5) ? 32'h01020304 : $urandom; in_trigger = 1;
            tick();
        end
        in_trigger = 0;
        tick();
        check("blk_count2", 64'(blk_count), 64'd2);
        check("blk_done256", 64'(blk_done), 64'd1);
        tick();
        check("blk_done_off", 64'(blk_done), 64'd0);
        for (int i = 0; i < 128; i++) begin
            in_data = $urandom; in_trigger = 1;
            tick();
        end
        in_trigger = 0;
        tick();
        check("blk_count3", 64'(blk_count), 64'd3);

        // level 9 with overflow, then frame_start alongside a push
        out_ready = 0;
        for (int i = 0; i < 18; i++) begin
            in_data = $urandom; in_trigger = 1;
            tick();
        end
        in_trigger = 0; out_ready = 1;
        repeat (7) tick();
        out_ready = 0;
        check("pre_fs_level", 64'(level), 64'd9);
        frame_start = 1; in_trigger = 1; in_data = 32'hDEADBEEF;
        tick();
        frame_start = 0; in_trigger = 0;
        check("fs_level", 64'(level), 64'd0);
        check("fs_ovf", 64'(overflow), 64'd0);
        check("fs_blk_count", 64'(blk_count), 64'd0);
        check("fs_blk_done", 64'(blk_done), 64'd0);

        // concurrent push and pop at level 5
        swap_mode = 2'd3;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom; in_trigger = 1;
            tick();
        end
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_data = $urandom;
            tick();
        end
        check("pp_level", 64'(level), 64'd5);
        out_ready = 0;
        repeat (2) tick();
        in_trigger = 0;
        check("pre_rst_level", 64'(level), 64'd7);

        // mid-stream reset
        rst_n = 0;
        tick();
        rst_n = 1;
        check("mrst_level", 64'(level), 64'd0);
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_busy", 64'(in_busy), 64'd0);
        swap_mode = 2'd0; in_data = 32'hCAFEBABE; in_trigger = 1;
        tick();
        in_trigger = 0;
        check("mrst_data", 64'(out_data), 64'hCAFEBABE);
        check("mrst_level1", 64'(level), 64'd1);

        // randomized traffic in phases of differing push/pop bias
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 750; i++) begin
                in_trigger  = $urandom_range(0, 99) < (p % 2 == 0 ? 70 : 35);
                out_ready   = $urandom_range(0, 99) < (p % 2 == 0 ? 35 : 80);
                in_data     = $urandom;
                swap_mode   = 2'($urandom_range(0, 3));
                frame_start = $urandom_range(0, 299) == 0;
                rst_n       = $urandom_range(0, 499) != 0;
                tick();
            end
        end
        in_trigger = 0; frame_start = 0; rst_n = 1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
